// File: rtl/toeplitz_stream.sv
// toeplitz_stream
// ---------------
// Streaming Toeplitz randomness extractor. Each block of N raw bits x is
// compressed into L output bits y = T*x over GF(2), where
// T[i][j] = s[i + N-1 - j]. Column j of T is therefore the L-bit window
// s[N-1-j +: L]. The seed s is loaded at run time.
//
// Stream bit j of a block is in_data[b] of word k, with j = k*W + b.
// Bit 0 of in_data is the earliest bit.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   seed       Toeplitz seed s[N+L-2:0], captured when seed_load=1
//   seed_load  load a new seed and discard any partial block
//   in_data    W raw bits, bit 0 earliest
//   in_valid   in_data valid
//   in_ready   a word can be accepted this cycle
//   out_data   last completed block y
//   out_valid  out_data holds an unread block
//   out_ready  consumer takes out_data
//   seeded     a seed has been loaded since reset
module toeplitz_stream #(
    parameter int N = 256,
    parameter int L = 128,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N+L-2:0]   seed,
    input  logic             seed_load,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [L-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             seeded
);

    localparam int SW    = N + L - 1;
    localparam int WORDS = N / W;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    logic [SW-1:0] seed_reg;
    logic [SW-1:0] win_reg;
    logic [L-1:0]  acc_reg;
    logic [CW-1:0] cnt;

    logic          last_word;
    logic          accept;
    logic [L-1:0]  y_next;

    // win_reg holds the seed shifted left by k*W for the current word k, so
    // the column for bit b of this word is always the fixed window
    // win_reg[N-1-b +: L]. That keeps the per-bit selection to wiring and
    // limits the XOR depth to W columns per cycle.
    always_comb begin
        last_word = (cnt == LAST_CNT);
        in_ready  = seeded & ~seed_load & ~(last_word & out_valid);
        accept    = in_valid & in_ready;
        y_next    = acc_reg;
        for (int b = 0; b < W; b++) begin
            if (in_data[b]) begin
                y_next = y_next ^ win_reg[N-1-b +: L];
            end
        end
    end

    // A seed load takes priority over an accept. in_ready is low in that
    // cycle anyway, so no word is ever mixed across seeds. The output
    // register is handled separately so a finished block survives a reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            seed_reg  <= '0;
            win_reg   <= '0;
            acc_reg   <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            seeded    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (seed_load) begin
                seed_reg <= seed;
                win_reg  <= seed;
                seeded   <= 1'b1;
                acc_reg  <= '0;
                cnt      <= '0;
            end else if (accept) begin
                if (last_word) begin
                    out_data  <= y_next;
                    out_valid <= 1'b1;
                    acc_reg   <= '0;
                    cnt       <= '0;
                    win_reg   <= seed_reg;
                end else begin
                    acc_reg <= y_next;
                    cnt     <= cnt + 1'b1;
                    win_reg <= win_reg << W;
                end
            end
        end
    end

endmodule

// File: tb/tb_toeplitz_stream.sv
// tb_toeplitz_stream
// ------------------
// Bench for toeplitz_stream. It instantiates two copies of the design.
//   - A small copy (N=8, L=4, W=2) runs directed scenarios:
//     identity seed, all-ones seed, backpressure, reload mid-block,
//     and reset mid-block.
//   - A default-size copy (N=256, L=128, W=8) runs a long random stream.
//     A block-level model follows the seed, the partial-block bits and the
//     output slot. Each finished block is computed bit-serially from the
//     matrix definition.
module tb_toeplitz_stream;

    logic clk;
    logic reset;

    logic [10:0]  s_seed;
    logic         s_seed_load;
    logic [1:0]   s_in_data;
    logic         s_in_valid;
    logic         s_in_ready;
    logic [3:0]   s_out_data;
    logic         s_out_valid;
    logic         s_out_ready;
    logic         s_seeded;

    logic [382:0] b_seed;
    logic         b_seed_load;
    logic [7:0]   b_in_data;
    logic         b_in_valid;
    logic         b_in_ready;
    logic [127:0] b_out_data;
    logic         b_out_valid;
    logic         b_out_ready;
    logic         b_seeded;

    int errors = 0;
    int checks = 0;

    toeplitz_stream #(.N(8), .L(4), .W(2)) dut_s (
        .clk(clk), .reset(reset), .seed(s_seed), .seed_load(s_seed_load),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .seeded(s_seeded)
    );

    toeplitz_stream dut_b (
        .clk(clk), .reset(reset), .seed(b_seed), .seed_load(b_seed_load),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .seeded(b_seeded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // y[i] = XOR over j of x[j] & s[i + n-1 - j], straight from the matrix definition
    function automatic logic [127:0] ref_block(input logic [382:0] s, input logic [255:0] x,
                                               input int n, input int l);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < l; i++) begin
            for (int j = 0; j < n; j++) begin
                if (x[j] && s[i + n - 1 - j]) begin
                    y[i] = ~y[i];
                end
            end
        end
        return y;
    endfunction

    function automatic logic [3:0] small_ref(input logic [10:0] s, input logic [7:0] x);
        logic [127:0] y;
        y = ref_block({372'b0, s}, {248'b0, x}, 8, 4);
        return y[3:0];
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one word to the small DUT, requires it to be taken, then drops valid.
    task automatic apply_stimulus(input string tag, input logic [1:0] d);
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data  = d;
        #1;
        check_output(tag, {127'b0, s_in_ready}, 128'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    task automatic s_load(input logic [10:0] sd, input logic v);
        @(negedge clk);
        s_seed      = sd;
        s_seed_load = 1'b1;
        s_in_valid  = v;
        s_in_data   = 2'b11;
        #1;
        check_output("s_ready_in_load", {127'b0, s_in_ready}, 128'd0);
        @(posedge clk);
        #1;
        s_seed_load = 1'b0;
        s_in_valid  = 1'b0;
    endtask

    task automatic s_read();
        @(negedge clk);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
    endtask

    task automatic s_block(input string tag, input logic [7:0] x);
        apply_stimulus({tag, "_w0"}, x[1:0]);
        apply_stimulus({tag, "_w1"}, x[3:2]);
        apply_stimulus({tag, "_w2"}, x[5:4]);
        apply_stimulus({tag, "_w3"}, x[7:6]);
    endtask

    // Big-DUT model state
    logic         m_seeded;
    logic [382:0] m_seed;
    logic [255:0] m_x;
    int           m_cnt;
    logic         m_out_valid;
    logic [127:0] m_out_data;

    initial begin
        logic [10:0]  sb;
        logic [10:0]  sn;
        logic [7:0]   xa;
        logic [7:0]   xb;
        logic [7:0]   xd;
        logic [3:0]   ya;
        logic [3:0]   yb;
        logic [383:0] new_seed;
        logic         ld;
        logic         v;
        logic         rdy;
        logic         done;
        logic         exp_ready;
        logic [7:0]   d;
        int           cyc;
        int           blocks_read;

        reset       = 1'b1;
        s_seed      = '0;  s_seed_load = 1'b0; s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        b_seed      = '0;  b_seed_load = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        new_seed    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, then in_valid held high before any seed
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data  = 2'b01;
        b_in_valid = 1'b1;
        #1;
        check_output("s_reset_out_data", {124'b0, s_out_data}, 128'd0);
        check_output("s_reset_out_valid", {127'b0, s_out_valid}, 128'd0);
        check_output("s_reset_seeded", {127'b0, s_seeded}, 128'd0);
        check_output("b_reset_out_data", b_out_data, 128'd0);
        check_output("b_reset_seeded", {127'b0, b_seeded}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_output("s_unseeded_in_ready", {127'b0, s_in_ready}, 128'd0);
            check_output("s_unseeded_out_valid", {127'b0, s_out_valid}, 128'd0);
            check_output("b_unseeded_in_ready", {127'b0, b_in_ready}, 128'd0);
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        b_in_valid = 1'b0;

        // Identity seed: y equals the first four stream bits
        s_load(11'h080, 1'b0);
        @(negedge clk);
        #1;
        check_output("s_seeded_after_load", {127'b0, s_seeded}, 128'd1);
        apply_stimulus("id_w0", 2'b01);
        apply_stimulus("id_w1", 2'b10);
        apply_stimulus("id_w2", 2'b11);
        @(negedge clk);
        #1;
        check_output("id_valid_before_last", {127'b0, s_out_valid}, 128'd0);
        apply_stimulus("id_w3", 2'b00);
        @(negedge clk);
        #1;
        check_output("id_out_valid", {127'b0, s_out_valid}, 128'd1);
        check_output("id_out_data", {124'b0, s_out_data}, 128'b1001);
        check_output("id_out_data_model", {124'b0, s_out_data}, {124'b0, small_ref(11'h080, 8'b00111001)});
        s_read();
        @(negedge clk);
        #1;
        check_output("id_valid_after_read", {127'b0, s_out_valid}, 128'd0);
        check_output("id_data_held", {124'b0, s_out_data}, 128'b1001);

        // All-ones seed: every output bit is the block parity
        s_load(11'h7FF, 1'b1);
        s_block("ones_a", 8'b00000001);
        @(negedge clk);
        #1;
        check_output("ones_odd_parity", {124'b0, s_out_data}, 128'b1111);
        s_read();
        s_block("ones_b", 8'b00111001);
        @(negedge clk);
        #1;
        check_output("ones_even_parity", {124'b0, s_out_data}, 128'b0000);
        s_read();

        // Backpressure with two back-to-back blocks
        sb = 11'b10110010110;
        xa = 8'b11011011;
        xb = 8'b01111001;
        ya = small_ref(sb, xa);
        yb = small_ref(sb, xb);
        s_load(sb, 1'b0);
        s_block("bp_a", xa);
        @(negedge clk);
        #1;
        check_output("bp_a_valid", {127'b0, s_out_valid}, 128'd1);
        check_output("bp_a_data", {124'b0, s_out_data}, {124'b0, ya});
        apply_stimulus("bp_b_w0", xb[1:0]);
        apply_stimulus("bp_b_w1", xb[3:2]);
        apply_stimulus("bp_b_w2", xb[5:4]);
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data  = xb[7:6];
        #1;
        check_output("bp_last_stall", {127'b0, s_in_ready}, 128'd0);
        @(negedge clk);
        #1;
        check_output("bp_last_stall2", {127'b0, s_in_ready}, 128'd0);
        check_output("bp_a_held", {124'b0, s_out_data}, {124'b0, ya});
        s_out_ready = 1'b1;
        #1;
        check_output("bp_same_cycle_ready", {127'b0, s_in_ready}, 128'd0);
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_output("bp_a_read_valid", {127'b0, s_out_valid}, 128'd0);
        check_output("bp_a_read_data", {124'b0, s_out_data}, {124'b0, ya});
        check_output("bp_last_ready", {127'b0, s_in_ready}, 128'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_output("bp_b_valid", {127'b0, s_out_valid}, 128'd1);
        check_output("bp_b_data", {124'b0, s_out_data}, {124'b0, yb});

        // Seed reload mid-block while block b is still unread
        sn = 11'b01101001101;
        xd = 8'b10100111;
        apply_stimulus("rl_c_w0", 2'b11);
        apply_stimulus("rl_c_w1", 2'b10);
        s_load(sn, 1'b1);
        @(negedge clk);
        #1;
        check_output("rl_valid_kept", {127'b0, s_out_valid}, 128'd1);
        check_output("rl_data_kept", {124'b0, s_out_data}, {124'b0, yb});
        s_read();
        s_block("rl_d", xd);
        @(negedge clk);
        #1;
        check_output("rl_d_valid", {127'b0, s_out_valid}, 128'd1);
        check_output("rl_d_data", {124'b0, s_out_data}, {124'b0, small_ref(sn, xd)});

        // Reset mid-block with an unread block
        apply_stimulus("rst_w0", 2'b01);
        apply_stimulus("rst_w1", 2'b11);
        @(negedge clk);
        reset      = 1'b1;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst_out_valid", {127'b0, s_out_valid}, 128'd0);
        check_output("rst_out_data", {124'b0, s_out_data}, 128'd0);
        check_output("rst_seeded", {127'b0, s_seeded}, 128'd0);
        check_output("rst_in_ready", {127'b0, s_in_ready}, 128'd0);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;

        // Long random stream on the default-size DUT
        m_seeded    = 1'b0;
        m_seed      = '0;
        m_x         = '0;
        m_cnt       = 0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        cyc         = 0;
        blocks_read = 0;
        while (blocks_read < 1000 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            ld = !m_seeded || (m_cnt == 0 && $urandom_range(7) == 0) || ($urandom_range(511) == 0);
            if (ld) begin
                for (int i = 0; i < 12; i++) begin
                    new_seed[i*32 +: 32] = $urandom;
                end
            end
            v   = ($urandom_range(7) != 0);
            d   = 8'($urandom);
            rdy = ($urandom_range(3) != 0);
            b_seed      = new_seed[382:0];
            b_seed_load = ld;
            b_in_valid  = v;
            b_in_data   = d;
            b_out_ready = rdy;
            #1;
            exp_ready = m_seeded && !ld && !(m_cnt == 31 && m_out_valid);
            check_output("big_in_ready", {127'b0, b_in_ready}, {127'b0, exp_ready});
            check_output("big_out_valid", {127'b0, b_out_valid}, {127'b0, m_out_valid});
            if (m_out_valid && rdy) begin
                check_output("big_block", b_out_data, m_out_data);
                blocks_read++;
            end
            done = 1'b0;
            if (ld) begin
                m_seed   = new_seed[382:0];
                m_seeded = 1'b1;
                m_cnt    = 0;
                m_x      = '0;
            end else if (v && exp_ready) begin
                m_x[m_cnt*8 +: 8] = d;
                if (m_cnt == 31) begin
                    m_out_data = ref_block(m_seed, m_x, 256, 128);
                    done       = 1'b1;
                    m_cnt      = 0;
                    m_x        = '0;
                end else begin
                    m_cnt++;
                end
            end
            if (m_out_valid && rdy) begin
                m_out_valid = 1'b0;
            end
            if (done) begin
                m_out_valid = 1'b1;
            end
        end
        @(negedge clk);
        b_seed_load = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        check_output("big_blocks_read", 128'(blocks_read), 128'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
